dmem_arbiter: RTL and testbench

//  Owns the 32x19 data memory and shares it between two requesters: the CPU

---
 rtl/dmem_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: 32x19 data memory shared by CPU and host ports, round-robin, one access per grant
module dmem_arbiter #(
   parameter int DW    = 19,
   parameter int AW    = 5,
   parameter int DEPTH = 32
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          busy
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          owner_q, owner_d;
   logic          prio_q, prio_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] host_rdata_q, host_rdata_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          acc, any_req, win;

   // power-on contents of the data memory
   function automatic logic [DW-1:0] init_word(input int i);
      return (i < 5) ? DW'(i + 1) : (i == 5) ? DW'(15) : '0;
   endfunction

   assign acc     = (state_q == S_ACCESS);
   assign any_req = cpu_req | host_req;
   // 1 selects the host; the pointer only matters when both ask at once
   assign win     = (cpu_req & host_req) ? prio_q : host_req;

   // next state: arbitrate whenever not in ACCESS, latch the winner's command
   always_comb begin
      state_d      = acc ? S_RESP : (any_req ? S_ACCESS : S_IDLE);
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      prio_d       = acc ? ~owner_q : prio_q;
      cpu_rdata_d  = (acc & ~we_q & ~owner_q) ? mem_q[addr_q] : cpu_rdata_q;
      host_rdata_d = (acc & ~we_q & owner_q) ? mem_q[addr_q] : host_rdata_q;
      if (!acc && any_req) begin
         owner_d = win;
         we_d    = win ? host_we : cpu_we;
         addr_d  = win ? host_addr : cpu_addr;
         wdata_d = win ? host_wdata : cpu_wdata;
      end
   end

   // control and response registers
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         prio_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         prio_q       <= prio_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         host_rdata_q <= host_rdata_d;
      end
   end

   // storage array; reset restores the boot contents, writes land at the end of ACCESS
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= init_word(i);
      end else if (acc && we_q) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign cpu_gnt    = acc & ~owner_q;
   assign host_gnt   = acc & owner_q;
   assign cpu_ack    = (state_q == S_RESP) & ~owner_q;
   assign host_ack   = (state_q == S_RESP) & owner_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign host_rdata = host_rdata_q;
   assign busy       = (state_q == S_ACCESS) | (state_q == S_RESP);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic on both ports, scoreboard against a transaction-level model
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        sys_rst_n = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
   logic [4:0]  cpu_addr = '0, host_addr = '0;
   logic [18:0] cpu_wdata = '0, host_wdata = '0;
   logic        cpu_gnt, cpu_ack, host_gnt, host_ack, busy;
   logic [18:0] cpu_rdata, host_rdata;

   typedef struct {
      bit          h;
      logic [18:0] d;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   exp_t        mdl_e;
   int          checks = 0;
   int          errors = 0;
   logic        e_gc, e_gh, e_ac, e_ah;
   logic [18:0] m_mem [32];
   logic [18:0] m_rd [2];
   bit          m_ptr, m_skip, mdl_h;
   int          lat;
   logic [18:0] rd;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .sys_rst_n(sys_rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata),
      .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_init();
      for (int i = 0; i < 32; i++) m_mem[i] = (i < 5) ? 19'(i + 1) : (i == 5) ? 19'h0000F : 19'h0;
      m_rd[0] = '0;
      m_rd[1] = '0;
      m_ptr   = 1'b0;
      m_skip  = 1'b0;
      {e_gc, e_gh, e_ac, e_ah} = '0;
      sbq.delete();
   endfunction

   // reference model: one access per two cycles, serialized in grant order
   initial begin
      model_init();
      forever begin
         @(posedge clk or negedge sys_rst_n);
         if (!sys_rst_n) model_init();
         else begin
            e_ac = e_gc;
            e_ah = e_gh;
            e_gc = 1'b0;
            e_gh = 1'b0;
            if (m_skip) m_skip = 1'b0;
            else if (cpu_req || host_req) begin
               mdl_h = (cpu_req && host_req) ? m_ptr : host_req;
               m_ptr = ~mdl_h;
               m_skip = 1'b1;
               if (mdl_h) e_gh = 1'b1;
               else e_gc = 1'b1;
               if (mdl_h ? host_we : cpu_we) m_mem[mdl_h ? host_addr : cpu_addr] = mdl_h ? host_wdata : cpu_wdata;
               else m_rd[mdl_h] = m_mem[mdl_h ? host_addr : cpu_addr];
               mdl_e.h = mdl_h;
               mdl_e.d = m_rd[mdl_h];
               sbq.push_back(mdl_e);
            end
         end
      end
   end

   // monitor: per-cycle handshake checks, scoreboard pop on every ack
   initial forever begin
      @(negedge clk);
      chk("cpu_gnt", cpu_gnt, e_gc);
      chk("host_gnt", host_gnt, e_gh);
      chk("cpu_ack", cpu_ack, e_ac);
      chk("host_ack", host_ack, e_ah);
      chk("busy", busy, e_gc | e_gh | e_ac | e_ah);
      chk("gnt_overlap", cpu_gnt & host_gnt, 0);
      if (cpu_ack || host_ack) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: ack with no expected response at %0t", $time);
         end else begin
            mon_e = sbq.pop_front();
            chk("ack_owner", host_ack, mon_e.h);
            chk("rdata", mon_e.h ? host_rdata : cpu_rdata, mon_e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic drive(input bit h, input bit r, input bit we, input logic [4:0] a, input logic [18:0] d);
      if (h) begin
         host_req = r; host_we = we; host_addr = a; host_wdata = d;
      end else begin
         cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      end
   endtask

   task automatic op(input bit h, input bit we, input logic [4:0] a, input logic [18:0] d,
                     output int l, output logic [18:0] r);
      @(posedge clk); #1;
      drive(h, 1'b1, we, a, d);
      l = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (h ? host_gnt : cpu_gnt) begin
            l = k;
            break;
         end
      end
      chk("op_gnt_seen", l >= 0, 1);
      @(posedge clk); #1;
      drive(h, 1'b0, we, a, d);
      @(negedge clk);
      chk("op_ack", h ? host_ack : cpu_ack, 1);
      r = h ? host_rdata : cpu_rdata;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      sys_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      sys_rst_n = 1'b1;
   endtask

   task automatic rnd_drv(input bit h, input int n);
      bit g;
      for (int i = 0; i < n; i++) begin
         drive(h, 1'b1, 1'($urandom), 5'($urandom_range(0, 7)), 19'($urandom));
         g = 1'b0;
         for (int k = 0; k < 40 && !g; k++) begin
            @(negedge clk);
            g = h ? host_gnt : cpu_gnt;
         end
         chk("rnd_gnt_seen", g, 1);
         @(posedge clk); #1;
         if ($urandom_range(0, 1) == 1) begin
            drive(h, 1'b0, 1'b0, '0, '0);
            repeat ($urandom_range(1, 2)) begin
               @(posedge clk); #1;
            end
         end
      end
      drive(h, 1'b0, 1'b0, '0, '0);
   endtask

   // directed scenarios, then randomized concurrent traffic
   initial begin
      int lat_h;
      logic [18:0] rd_h;
      #1 sys_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {cpu_gnt, cpu_ack, host_gnt, host_ack, busy}, 0);
      chk("rst_rdata", {cpu_rdata, host_rdata}, 0);
      #2 sys_rst_n = 1'b1;
      op(1'b0, 1'b0, 5'd4, '0, lat, rd);
      chk("t1_latency", lat, 1);
      chk("t1_rdata", rd, 19'h00005);
      chk("t1_host_quiet", {host_gnt, host_ack, host_rdata}, 0);
      op(1'b1, 1'b1, 5'd10, 19'h7ABCD, lat, rd);
      op(1'b0, 1'b0, 5'd10, '0, lat, rd);
      chk("t2_rdata", rd, 19'h7ABCD);
      do_reset();
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 5'd1, '0);
      drive(1'b1, 1'b1, 1'b0, 5'd2, '0);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("t3_cpu_gnt", cpu_gnt, (k % 4) == 1);
         chk("t3_host_gnt", host_gnt, (k % 4) == 3);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (4) @(negedge clk);
      do_reset();
      fork
         op(1'b0, 1'b1, 5'd3, 19'h12345, lat, rd);
         op(1'b1, 1'b0, 5'd3, '0, lat_h, rd_h);
      join
      chk("t4_cpu_first", lat < lat_h, 1);
      chk("t4_host_rdata", rd_h, 19'h12345);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b1, 5'd0, 19'h55555);
      @(negedge clk);
      @(negedge clk);
      chk("t6_gnt", cpu_gnt, 1);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("t6_busy_now", busy, 0);
      chk("t6_gnt_now", cpu_gnt, 0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk); #2;
      sys_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t6_no_ack", cpu_ack, 0);
      end
      op(1'b0, 1'b0, 5'd0, '0, lat, rd);
      chk("t6_rdata", rd, 19'h00001);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 5'd1, '0);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b1, 5'd7, 19'h3FFFF);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_no_host", {host_gnt, host_ack}, 0);
      end
      op(1'b0, 1'b0, 5'd7, '0, lat, rd);
      chk("t5_mem_kept", rd, 19'h0);
      fork
         rnd_drv(1'b0, 150);
         rnd_drv(1'b1, 150);
      join
      repeat (6) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
